// File: rtl/load_pkg.sv
// Shared definitions for the load path: op encodings, FSM states, default widths
// and the legality/alignment helpers used by the load unit.
package load_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned OP_W       = 3;
   localparam int unsigned REG_IDX_W  = 5;
   localparam int unsigned OFFSET_W   = 16;

   localparam logic [OP_W-1:0] OP_LB  = 3'd0;
   localparam logic [OP_W-1:0] OP_LH  = 3'd1;
   localparam logic [OP_W-1:0] OP_LW  = 3'd2;
   localparam logic [OP_W-1:0] OP_LBU = 3'd4;
   localparam logic [OP_W-1:0] OP_LHU = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_REQ   = 3'd2,
      ST_WAIT  = 3'd3,
      ST_WB    = 3'd4,
      ST_ERR   = 3'd5
   } load_state_e;

   // True for the five defined load encodings.
   function automatic logic op_legal(input logic [OP_W-1:0] op);
      return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
             (op == OP_LBU) || (op == OP_LHU);
   endfunction

   // True when the low address bits violate the natural alignment of the access.
   function automatic logic misaligned(input logic [OP_W-1:0] op, input logic [1:0] ea_lo);
      logic bad;
      bad = 1'b0;
      if (op == OP_LW)
         bad = (ea_lo != 2'b00);
      else if ((op == OP_LH) || (op == OP_LHU))
         bad = ea_lo[0];
      return bad;
   endfunction

endpackage

// File: rtl/load_align.sv
// Combinational lane select and sign/zero extension of a little-endian memory word.
// Ports: op (load type), ea_lo (effective address bits [1:0]), rdata (raw word),
//        result (aligned, extended value). Illegal ops pass rdata through.
module load_align
   import load_pkg::*;
(
   input  logic [OP_W-1:0]       op,
   input  logic [1:0]            ea_lo,
   input  logic [DATA_W_DEF-1:0] rdata,
   output logic [DATA_W_DEF-1:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed byte and halfword lanes.
   always_comb begin
      byte_sel = rdata[7:0];
      case (ea_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = ea_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   // Extend according to the load type.
   always_comb begin
      result = rdata;
      case (op)
         OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  result = {24'd0, byte_sel};
         OP_LH:   result = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  result = {16'd0, half_sel};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/load_unit.sv
// Multi-cycle load unit: computes ea = base + sext(offset), checks alignment,
// fetches the word over a req/gnt/rvalid handshake, aligns/extends it and
// drives the register file write port.
// Ports: clk, reset (async active-low); start/op/base/offset/dest_reg issue side;
//        busy; mem_req/mem_addr/mem_gnt/mem_rvalid/mem_rdata memory side;
//        reg_write/write_reg/write_data register file side; load_err error pulse.
module load_unit
   import load_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [OP_W-1:0]       op,
   input  logic [ADDR_W-1:0]     base,
   input  logic [OFFSET_W-1:0]   offset,
   input  logic [REG_IDX_W-1:0]  dest_reg,
   output logic                  busy,
   output logic                  mem_req,
   output logic [ADDR_W-1:0]     mem_addr,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  reg_write,
   output logic [REG_IDX_W-1:0]  write_reg,
   output logic [DATA_W-1:0]     write_data,
   output logic                  load_err
);

   load_state_e            state_q, state_d;
   logic [OP_W-1:0]        op_q;
   logic [ADDR_W-1:0]      ea_q;
   logic [REG_IDX_W-1:0]   dest_q;
   logic [ADDR_W-1:0]      ea_c;
   logic                   accept;
   logic                   capture;
   logic [DATA_W_DEF-1:0]  aligned;

   assign ea_c    = base + {{(ADDR_W-OFFSET_W){offset[OFFSET_W-1]}}, offset};
   assign accept  = (state_q == ST_IDLE) && start;
   assign capture = (state_q == ST_WAIT) && mem_rvalid;

   load_align u_align (
      .op     (op_q),
      .ea_lo  (ea_q[1:0]),
      .rdata  (DATA_W_DEF'(mem_rdata)),
      .result (aligned)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_CHECK;
         ST_CHECK: begin
            if (!op_legal(op_q) || misaligned(op_q, ea_q[1:0]))
               state_d = ST_ERR;
            else
               state_d = ST_REQ;
         end
         ST_REQ:   if (mem_gnt) state_d = ST_WAIT;
         ST_WAIT:  if (mem_rvalid) state_d = ST_WB;
         ST_WB:    state_d = ST_IDLE;
         ST_ERR:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Request context latched on accept.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q   <= '0;
         ea_q   <= '0;
         dest_q <= '0;
      end else if (accept) begin
         op_q   <= op;
         ea_q   <= ea_c;
         dest_q <= dest_reg;
      end
   end

   // Output registers, driven from the next state so each flag lines up with its state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy       <= 1'b0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         reg_write  <= 1'b0;
         write_reg  <= '0;
         write_data <= '0;
         load_err   <= 1'b0;
      end else begin
         busy      <= (state_d != ST_IDLE);
         mem_req   <= (state_d == ST_REQ);
         reg_write <= (state_d == ST_WB) && (dest_q != '0);
         load_err  <= (state_d == ST_ERR);
         // Address is loaded once on entry to REQ and held through the handshake.
         if ((state_q == ST_CHECK) && (state_d == ST_REQ))
            mem_addr <= {ea_q[ADDR_W-1:2], 2'b00};
         if (capture) begin
            write_reg  <= dest_q;
            write_data <= DATA_W'(aligned);
         end
      end
   end

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit with a cycle-accurate memory responder.
module tb_load_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] base;
   logic [15:0] offset;
   logic [4:0]  dest_reg;
   logic        busy;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        reg_write;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic        load_err;

   int n_vec;
   int n_err;

   load_unit dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .op         (op),
      .base       (base),
      .offset     (offset),
      .dest_reg   (dest_reg),
      .busy       (busy),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .reg_write  (reg_write),
      .write_reg  (write_reg),
      .write_data (write_data),
      .load_err   (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one load in the current cycle (cycle 0) and play the memory side.
   // exp_wr < 0 means no reg_write pulse; exp_errc < 0 means no load_err pulse.
   task automatic run_load(input string tag, input logic [2:0] o, input logic [31:0] b,
                           input logic [15:0] off, input logic [4:0] d,
                           input int gd, input int rd, input logic [31:0] rdat,
                           input logic [31:0] exp_addr, input int exp_wr,
                           input int exp_errc, input logic [31:0] exp_data,
                           input int exp_idle, input bit inject);
      int req_cyc, gnt_cyc, wr_cyc, err_cyc, idle_cyc, wr_cnt, err_cnt;
      bit req_seen, moved;
      logic [31:0] addr0, wd;
      logic [4:0] wreg;
      req_cyc = -1; gnt_cyc = -1; wr_cyc = -1; err_cyc = -1; idle_cyc = -1;
      wr_cnt = 0; err_cnt = 0; req_seen = 0; moved = 0; addr0 = '0; wd = '0; wreg = '0;
      op = o; base = b; offset = off; dest_reg = d;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (mem_req) begin
            if (!req_seen) begin
               req_seen = 1; req_cyc = cyc; addr0 = mem_addr;
            end else if (mem_addr !== addr0) moved = 1;
         end
         if (reg_write) begin
            wr_cnt++; wr_cyc = cyc; wd = write_data; wreg = write_reg;
         end
         if (load_err) begin
            err_cnt++; err_cyc = cyc;
         end
         if (cyc > 0 && !busy) begin
            idle_cyc = cyc;
            break;
         end
         start = (cyc == 0) || (inject && cyc == 3);
         if (inject && cyc == 3) begin
            base = 32'h0000_0F00; dest_reg = 5'd31; op = 3'd1;
         end
         mem_gnt = req_seen && mem_req && (cyc == req_cyc + gd);
         if (mem_gnt) gnt_cyc = cyc;
         mem_rvalid = (gnt_cyc >= 0) && (cyc == gnt_cyc + 1 + rd);
         mem_rdata  = mem_rvalid ? rdat : ~rdat;
         tick();
      end
      start = 0; mem_gnt = 0; mem_rvalid = 0;
      check({tag, ".idle"}, 32'(idle_cyc), 32'(exp_idle));
      check({tag, ".wr_cyc"}, 32'(wr_cyc), 32'(exp_wr));
      check({tag, ".err_cyc"}, 32'(err_cyc), 32'(exp_errc));
      check({tag, ".wr_cnt"}, 32'(wr_cnt), (exp_wr >= 0) ? 32'd1 : 32'd0);
      if (exp_errc < 0) begin
         check({tag, ".req_cyc"}, 32'(req_cyc), 32'd2);
         check({tag, ".addr"}, addr0, exp_addr);
         check({tag, ".addr_stable"}, 32'(moved), 32'd0);
      end else begin
         check({tag, ".no_req"}, 32'(req_seen), 32'd0);
         check({tag, ".err_cnt"}, 32'(err_cnt), 32'd1);
      end
      if (exp_wr >= 0) begin
         check({tag, ".data"}, wd, exp_data);
         check({tag, ".wreg"}, 32'(wreg), 32'(d));
      end
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      reset = 0; start = 0; op = 0; base = 0; offset = 0; dest_reg = 0;
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
      tick(); tick();
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.outs", {29'd0, mem_req, reg_write, load_err}, 32'd0);
      check("rst.addr", mem_addr, 32'd0);
      check("rst.wdata", write_data, 32'd0);
      // Release reset with a stale rvalid still asserted; it must be ignored.
      @(negedge clk); reset = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stale.rvalid", {30'd0, busy, reg_write}, 32'd0);
      end
      mem_rvalid = 0;

      run_load("lw",    3'd2, 32'h0000_0100, 16'h0004, 5'd2,  0, 0, 32'hDEAD_BEEF,
               32'h0000_0104, 4, -1, 32'hDEAD_BEEF, 5, 0);
      run_load("lb",    3'd0, 32'h0000_0100, 16'h0003, 5'd5,  0, 0, 32'h80FF_1234,
               32'h0000_0100, 4, -1, 32'hFFFF_FF80, 5, 0);
      run_load("lbu",   3'd4, 32'h0000_0100, 16'h0003, 5'd6,  0, 0, 32'h80FF_1234,
               32'h0000_0100, 4, -1, 32'h0000_0080, 5, 0);
      run_load("lb1",   3'd0, 32'h0000_0100, 16'h0001, 5'd8,  0, 0, 32'h80FF_1234,
               32'h0000_0100, 4, -1, 32'h0000_0012, 5, 0);
      run_load("lbu2",  3'd4, 32'h0000_0100, 16'h0002, 5'd9,  0, 0, 32'h80FF_1234,
               32'h0000_0100, 4, -1, 32'h0000_00FF, 5, 0);
      run_load("lh",    3'd1, 32'h0000_0100, 16'h0002, 5'd3,  0, 0, 32'hCAFE_BABE,
               32'h0000_0100, 4, -1, 32'hFFFF_CAFE, 5, 0);
      run_load("lh_mis",3'd1, 32'h0000_0100, 16'h0001, 5'd4,  0, 0, 32'hCAFE_BABE,
               32'h0, -1, 2, 32'h0, 3, 0);
      check("hold.wdata", write_data, 32'hFFFF_CAFE);
      run_load("lhu",   3'd5, 32'h0000_0300, 16'h0000, 5'd10, 0, 0, 32'h1234_8001,
               32'h0000_0300, 4, -1, 32'h0000_8001, 5, 0);
      run_load("lh_lo", 3'd1, 32'h0000_0300, 16'h0000, 5'd11, 0, 0, 32'h1234_8001,
               32'h0000_0300, 4, -1, 32'hFFFF_8001, 5, 0);
      run_load("lw_mis",3'd2, 32'h0000_0300, 16'h0002, 5'd12, 0, 0, 32'h1,
               32'h0, -1, 2, 32'h0, 3, 0);
      run_load("ill_op",3'd6, 32'h0000_0300, 16'h0000, 5'd12, 0, 0, 32'h1,
               32'h0, -1, 2, 32'h0, 3, 0);
      run_load("stall", 3'd2, 32'h0000_0200, 16'hFFF8, 5'd7,  3, 2, 32'h1234_5678,
               32'h0000_01F8, 9, -1, 32'h1234_5678, 10, 1);
      run_load("r0",    3'd2, 32'h0000_0100, 16'h0000, 5'd0,  0, 0, 32'h0BAD_F00D,
               32'h0000_0100, -1, -1, 32'h0, 5, 0);
      run_load("wrap",  3'd2, 32'hFFFF_FFFC, 16'h0008, 5'd13, 0, 0, 32'hA5A5_0001,
               32'h0000_0004, 4, -1, 32'hA5A5_0001, 5, 0);

      // Reset in WAIT: outputs clear asynchronously and a late rvalid is ignored.
      op = 3'd2; base = 32'h0000_0400; offset = 16'h0000; dest_reg = 5'd3; start = 1;
      tick(); start = 0;
      tick();
      check("mr.req", 32'(mem_req), 32'd1);
      mem_gnt = 1;
      tick(); mem_gnt = 0;
      check("mr.busy_wait", 32'(busy), 32'd1);
      reset = 0;
      #1;
      check("mr.flags", {28'd0, busy, mem_req, reg_write, load_err}, 32'd0);
      check("mr.addr", mem_addr, 32'd0);
      check("mr.wreg", 32'(write_reg), 32'd0);
      check("mr.wdata", write_data, 32'd0);
      #2 reset = 1;
      mem_rvalid = 1; mem_rdata = 32'h1111_2222;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("mr.late_rvalid", {30'd0, busy, reg_write}, 32'd0);
      end
      mem_rvalid = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/load_unit.md
# load_unit

Multi-cycle load unit for the execution-cycle datapath. Sits directly downstream of `register_file`: it takes the base address from `reg_data1` and a sign-extended 16-bit offset, fetches the word from data memory over a request/grant/response handshake, aligns and extends the selected byte, halfword or word, and drives the register file write port (`reg_write`, `write_reg`, `write_data`) to complete the load.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width.
- `DATA_W`, 32, memory and register data width; fixed at 32 for this revision.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue a load; sampled only when `busy`=0.
- `op`  in  3  load type: LB=0, LH=1, LW=2, LBU=4, LHU=5; other codes are illegal.
- `base`  in  32  base address, driven from `reg_data1`.
- `offset`  in  16  signed immediate.
- `dest_reg`  in  5  destination register index.
- `busy`  out  1  high whenever state is not IDLE.
- `mem_req`  out  1  memory read request.
- `mem_addr`  out  ADDR_W  word-aligned address: {ea[31:2], 2'b00}.
- `mem_gnt`  in  1  memory accepted the request.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  32  read data, little-endian.
- `reg_write`  out  1  one-cycle write-enable pulse to `register_file`.
- `write_reg`  out  5  destination index.
- `write_data`  out  32  aligned and extended result.
- `load_err`  out  1  one-cycle pulse on a misaligned address or illegal `op`.

## Operation
- Effective address ea = base + sign_extend(offset), modulo 2^32. Wrap-around is legal and raises no error.
- On accept (`start`=1, `busy`=0), latch `op`, ea and `dest_reg`.
- FSM states:
  - IDLE -> CHECK on accept.
  - CHECK -> ERR if LW and ea[1:0]≠0, if LH/LHU and ea[0]≠0, or if `op` is illegal; otherwise -> REQ.
  - REQ holds `mem_req`=1 with a stable `mem_addr` until `mem_gnt`; -> WAIT on grant.
  - WAIT -> WB on `mem_rvalid`; the result is captured the same cycle.
  - WB pulses `reg_write` -> IDLE.
  - ERR pulses `load_err` -> IDLE. No memory request is issued and no register write occurs.
- Lane select (little-endian):
  - byte = rdata[8*ea[1:0] +: 8]
  - half = rdata[16*ea[1] +: 16]
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- `dest_reg`=0: the full transaction runs but `reg_write` stays 0 in WB.
- `start` while `busy`=1 is ignored. It is neither queued nor flagged.
- `mem_rvalid` outside WAIT is ignored, including a stale response after reset.

## Timing
- Reset values: `busy`, `mem_req`, `reg_write` and `load_err` are 0; `mem_addr`, `write_reg` and `write_data` are 0; state is IDLE.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Cycle 0: `start` accepted. Cycle 1: CHECK. Cycle 2: `mem_req`=1.
- With grant in cycle 2 and `mem_rvalid` in cycle 3, `reg_write` is high in cycle 4. Minimum latency from start to write is 4 cycles. Each stall cycle on grant or rvalid adds one cycle.
- Error path: `load_err` is high in cycle 2, and `busy` falls in cycle 3.
- `write_reg`/`write_data` are valid in the same cycle as `reg_write` and hold until the next WB.
- `busy` goes low the cycle after WB/ERR. The next `start` can be accepted that same cycle.
- Reset asserted mid-operation: outputs clear immediately (asynchronously) and the in-flight load is abandoned. The memory side must tolerate a request that is dropped.

## Structure
- Shared package `load_pkg`: `op` encoding constants (LB/LH/LW/LBU/LHU), state enum, and `ADDR_W`/`DATA_W` defaults.
- One sub-module `load_align`: combinational lane select and extension (inputs `op`, `ea[1:0]`, `rdata`; output 32-bit result), reusable by the later store path.
- Top `load_unit` contains the FSM, the ea adder, the alignment check and the output registers.

## Test plan
- LW, base=0x100, offset=+4, rdata=0xDEADBEEF, `dest_reg`=2, grant and rvalid immediate -> `mem_addr`=0x104; `reg_write` in cycle 4 with `write_reg`=2 and `write_data`=0xDEADBEEF.
- LB then LBU, ea=0x103, rdata=0x80FF1234 -> LB writes 0xFFFFFF80; LBU writes 0x00000080.
- LH, ea=0x102 and rdata=0xCAFEBABE -> write 0xFFFFCAFE. LH, ea=0x101 -> `load_err` pulse in cycle 2, no `mem_req`, no `reg_write`.
- Grant delayed 3 cycles and rvalid delayed 2 cycles -> `mem_addr` stable throughout REQ; `reg_write` in cycle 9. A `start` issued mid-transaction is ignored.
- LW with `dest_reg`=0 -> memory transaction completes and `reg_write` stays 0. base=0xFFFFFFFC with offset=+8 -> `mem_addr`=0x00000004, no error.
- `reset` driven low while in WAIT -> all outputs 0 immediately; a later `mem_rvalid` produces no `reg_write`.
